io_timer: RTL and testbench

IO_TIMER -- requirements
Module: io_timer

---
 rtl/io_timer_pkg.sv | 11 +
 rtl/constants.vh | 23 ++
 rtl/io_timer.sv | 150 +++++++++++++++
 tb/tb_io_timer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_timer_pkg.sv
// Shared types for io_timer: read-handshake FSM states and the control/status field width.
package io_timer_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  localparam int FLAG_W = 3;

endpackage

// File: rtl/constants.vh
// Register map, control/status bit positions and reset values shared by the io_timer design.
`ifndef IO_TIMER_CONSTANTS_VH
`define IO_TIMER_CONSTANTS_VH

`define IOT_OFF_CTRL    3'd0
`define IOT_OFF_COUNT   3'd1
`define IOT_OFF_CMP     3'd2
`define IOT_OFF_PRESC   3'd3
`define IOT_OFF_STATUS  3'd4
`define IOT_OFF_CAP     3'd5

`define IOT_CTRL_EN     0
`define IOT_CTRL_AUTO   1
`define IOT_CTRL_IE     2

`define IOT_ST_MATCH    0
`define IOT_ST_OVF      1
`define IOT_ST_CAPF     2

`define IOT_CMP_RESET   16'hFFFF
`define IOT_PRESC_RESET 16'h0000

`endif

// File: rtl/io_timer.sv
// Memory-mapped 16-bit timer with prescaler, compare match, overflow and optional input capture.
// Capture is built only when IO_TIMER_CAPTURE_EN is defined; otherwise CAP and CAPF read 0.
`include "constants.vh"

module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [7:0] BASE_HI = 8'h81
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_rdy,
  input  logic        i_cap,
  output logic        o_irq
);

  logic              hit;
  logic [2:0]        off;
  logic              wr;
  logic              rd_req;
  logic              count_wr;
  logic              tick;
  logic              match_ev;
  logic              ovf_ev;
  logic              capf_ev;
  logic [FLAG_W-1:0] ctrl;
  logic [FLAG_W-1:0] status;
  logic [15:0]       count;
  logic [15:0]       cmp;
  logic [15:0]       presc;
  logic [15:0]       prescale;
  logic [15:0]       cap;
  logic [15:0]       sel_data;
  logic [15:0]       read_data;
  rd_state_t         state;
  rd_state_t         next_state;
  logic              unused_addr;

  assign hit         = i_sel && (i_addr[15:8] == BASE_HI);
  assign off         = i_addr[3:1];
  assign wr          = hit && i_we;
  assign rd_req      = hit && i_re;
  assign count_wr    = wr && (off == `IOT_OFF_COUNT);
  assign unused_addr = ^{i_addr[7:4], i_addr[0]};

  // A COUNT write takes the cycle over completely, so a coincident tick is dropped.
  assign tick     = ctrl[`IOT_CTRL_EN] && (prescale == presc) && !count_wr;
  assign match_ev = tick && (count == cmp);
  assign ovf_ev   = tick && (count != cmp) && (count == 16'hFFFF);

`ifdef IO_TIMER_CAPTURE_EN
  logic cap_prev;

  assign capf_ev = i_cap && !cap_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_prev <= 1'b0;
      cap      <= 16'h0000;
    end else begin
      cap_prev <= i_cap;
      if (capf_ev) cap <= count;
    end
  end
`else
  logic unused_cap;

  assign unused_cap = i_cap;
  assign capf_ev    = 1'b0;
  assign cap        = 16'h0000;
`endif

  always_comb begin
    sel_data = 16'h0000;
    case (off)
      `IOT_OFF_CTRL:   sel_data = {13'd0, ctrl};
      `IOT_OFF_COUNT:  sel_data = count;
      `IOT_OFF_CMP:    sel_data = cmp;
      `IOT_OFF_PRESC:  sel_data = presc;
      `IOT_OFF_STATUS: sel_data = {13'd0, status};
      `IOT_OFF_CAP:    sel_data = cap;
      default:         sel_data = 16'h0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl     <= '0;
      count    <= 16'h0000;
      cmp      <= `IOT_CMP_RESET;
      presc    <= `IOT_PRESC_RESET;
      status   <= '0;
      prescale <= 16'h0000;
    end else begin
      if (wr && (off == `IOT_OFF_CTRL))  ctrl  <= i_wdata[FLAG_W-1:0];
      if (wr && (off == `IOT_OFF_CMP))   cmp   <= i_wdata;
      if (wr && (off == `IOT_OFF_PRESC)) presc <= i_wdata;

      if (count_wr) begin
        count    <= i_wdata;
        prescale <= 16'h0000;
      end else if (ctrl[`IOT_CTRL_EN]) begin
        prescale <= (prescale == presc) ? 16'h0000 : prescale + 16'd1;
        if (tick) count <= (match_ev && ctrl[`IOT_CTRL_AUTO]) ? 16'h0000 : count + 16'd1;
      end

      // Clear first, then OR in new events so a same-cycle set survives the write-1-to-clear.
      status <= ((wr && (off == `IOT_OFF_STATUS)) ? (status & ~i_wdata[FLAG_W-1:0]) : status)
                | {capf_ev, ovf_ev, match_ev};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      read_data <= 16'h0000;
    end else begin
      state <= next_state;
      if ((state == IDLE) && rd_req) read_data <= sel_data;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rd_req) next_state = RD_DATA;
      RD_DATA: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_rdy   = 1'b1;
    o_rdata = 16'h0000;
    case (state)
      IDLE:    o_rdy = !rd_req;
      RD_DATA: o_rdata = read_data;
      default: o_rdy = 1'b1;
    endcase
  end

  assign o_irq = ctrl[`IOT_CTRL_IE] && (status[`IOT_ST_MATCH] || status[`IOT_ST_OVF]);

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios plus random bus traffic against a cycle model.
// Capture expectations follow IO_TIMER_CAPTURE_EN the same way the design does.
module tb_io_timer;

`ifdef IO_TIMER_CAPTURE_EN
  localparam bit CAP_ON = 1'b1;
`else
  localparam bit CAP_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_addr = 16'h0000;
  logic        i_sel = 1'b0;
  logic        i_we = 1'b0;
  logic        i_re = 1'b0;
  logic [15:0] i_wdata = 16'h0000;
  logic [15:0] o_rdata;
  logic        o_rdy;
  logic        i_cap = 1'b0;
  logic        o_irq;

  int checks = 0;
  int failures = 0;
  logic cap_level = 1'b0;

  // Reference model state, advanced once per clock from the register-level rules.
  logic [2:0]  m_ctrl, m_status;
  logic [15:0] m_count, m_cmp, m_presc, m_pre, m_cap, m_pval;
  logic        m_cap_prev, m_pending;

  io_timer #(.BASE_HI(8'h81)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_sel(i_sel), .i_we(i_we),
    .i_re(i_re), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rdy(o_rdy),
    .i_cap(i_cap), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] reg_addr(input logic [2:0] o);
    reg_addr = {8'h81, 4'h0, o, 1'b0};
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] o);
    case (o)
      3'd0:    model_read = {13'd0, m_ctrl};
      3'd1:    model_read = m_count;
      3'd2:    model_read = m_cmp;
      3'd3:    model_read = m_presc;
      3'd4:    model_read = {13'd0, m_status};
      3'd5:    model_read = m_cap;
      default: model_read = 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 3'd0; m_status = 3'd0; m_count = 16'h0; m_cmp = 16'hFFFF; m_presc = 16'h0;
    m_pre = 16'h0; m_cap = 16'h0; m_pval = 16'h0; m_cap_prev = 1'b0; m_pending = 1'b0;
  endtask

  // One bus cycle: drive, check the pre-edge outputs against the model, clock, advance model.
  task automatic applyStimulus(input logic rst, input logic sel, input logic [15:0] addr,
                               input logic we, input logic re, input logic [15:0] wdata,
                               output logic [15:0] rdata);
    logic hit, cw;
    logic [2:0] o, n_ctrl, n_status, sets;
    logic [15:0] n_count, n_cmp, n_presc, n_pre, n_cap, n_pval;
    logic n_cap_prev, n_pending;
    i_rst = rst; i_sel = sel; i_addr = addr; i_we = we; i_re = re; i_wdata = wdata;
    i_cap = cap_level;
    #1;
    hit = sel && (addr[15:8] == 8'h81);
    o = addr[3:1];
    checkOutput("rdy", {15'd0, o_rdy}, {15'd0, m_pending || !(hit && re)});
    checkOutput("rdata", o_rdata, m_pending ? m_pval : 16'h0000);
    checkOutput("irq", {15'd0, o_irq}, {15'd0, m_ctrl[2] && (m_status[0] || m_status[1])});
    rdata = o_rdata;

    n_ctrl = m_ctrl; n_count = m_count; n_cmp = m_cmp; n_presc = m_presc; n_pre = m_pre;
    n_cap = m_cap; n_cap_prev = m_cap_prev; n_status = m_status; sets = 3'd0;
    cw = hit && we && (o == 3'd1);
    if (hit && we) begin
      case (o)
        3'd0: n_ctrl = wdata[2:0];
        3'd1: begin n_count = wdata; n_pre = 16'h0; end
        3'd2: n_cmp = wdata;
        3'd3: n_presc = wdata;
        3'd4: n_status = m_status & ~wdata[2:0];
        default: ;
      endcase
    end
    if (!cw && m_ctrl[0]) begin
      if (m_pre == m_presc) begin
        n_pre = 16'h0;
        if (m_count == m_cmp) begin
          sets[0] = 1'b1;
          n_count = m_ctrl[1] ? 16'h0 : m_count + 16'd1;
        end else if (m_count == 16'hFFFF) begin
          sets[1] = 1'b1;
          n_count = 16'h0;
        end else begin
          n_count = m_count + 16'd1;
        end
      end else begin
        n_pre = m_pre + 16'd1;
      end
    end
    if (CAP_ON) begin
      if (cap_level && !m_cap_prev) begin
        n_cap = m_count;
        sets[2] = 1'b1;
      end
      n_cap_prev = cap_level;
    end
    n_status = n_status | sets;
    n_pending = !m_pending && hit && re;
    n_pval = n_pending ? model_read(o) : m_pval;

    @(posedge i_clk);
    if (rst) begin
      model_reset();
    end else begin
      m_ctrl = n_ctrl; m_count = n_count; m_cmp = n_cmp; m_presc = n_presc; m_pre = n_pre;
      m_cap = n_cap; m_cap_prev = n_cap_prev; m_status = n_status;
      m_pending = n_pending; m_pval = n_pval;
    end
    #1;
  endtask

  task automatic write_reg(input logic [2:0] o, input logic [15:0] d);
    logic [15:0] dummy;
    applyStimulus(1'b0, 1'b1, reg_addr(o), 1'b1, 1'b0, d, dummy);
  endtask

  task automatic bus_read(input logic [2:0] o, output logic [15:0] d);
    logic [15:0] dummy;
    applyStimulus(1'b0, 1'b1, reg_addr(o), 1'b0, 1'b1, 16'h0, dummy);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, d);
  endtask

  task automatic idle(input int n);
    logic [15:0] dummy;
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, dummy);
  endtask

  task automatic wait_irq(input string tag, input int expect_cycles);
    int n;
    n = 0;
    while (!o_irq && n < 40) begin
      idle(1);
      n++;
    end
    checkOutput(tag, 16'(n), 16'(expect_cycles));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] d, dummy, a;
    int op;
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    i_rst = 1'b0;

    // Reset values.
    checkOutput("reset_rdy", {15'd0, o_rdy}, 16'h0001);
    checkOutput("reset_irq", {15'd0, o_irq}, 16'h0000);
    for (int r = 0; r < 6; r++) begin
      bus_read(3'(r), d);
      checkOutput("reset_reg", d, (r == 2) ? 16'hFFFF : 16'h0000);
    end

    // Compare match on the 4th tick with auto reload.
    write_reg(3'd3, 16'h0000);
    write_reg(3'd2, 16'h0003);
    write_reg(3'd0, 16'h0007);
    wait_irq("match_ticks", 4);
    bus_read(3'd1, d);
    checkOutput("count_after_match", d, 16'h0000);
    write_reg(3'd0, 16'h0000);
    write_reg(3'd4, 16'h0007);

    // Read handshake and unselected read.
    write_reg(3'd1, 16'h00A5);
    bus_read(3'd1, d);
    checkOutput("count_readback", d, 16'h00A5);
    applyStimulus(1'b0, 1'b0, reg_addr(3'd1), 1'b0, 1'b1, 16'h0, dummy);
    checkOutput("nosel_rdy", {15'd0, o_rdy}, 16'h0001);
    bus_read(3'd7, d);
    checkOutput("reserved_read", d, 16'h0000);

    // Overflow with PRESC=1 and its write-1-to-clear.
    write_reg(3'd2, 16'h1234);
    write_reg(3'd3, 16'h0001);
    write_reg(3'd0, 16'h0005);
    write_reg(3'd1, 16'hFFFE);
    wait_irq("ovf_cycles", 4);
    write_reg(3'd4, 16'h0002);
    checkOutput("ovf_cleared_irq", {15'd0, o_irq}, 16'h0000);
    write_reg(3'd0, 16'h0000);

    // Clear of MATCH coinciding with a new match leaves MATCH set.
    write_reg(3'd4, 16'h0007);
    write_reg(3'd2, 16'h0000);
    write_reg(3'd3, 16'h0000);
    write_reg(3'd1, 16'h0000);
    write_reg(3'd0, 16'h0003);
    idle(2);
    write_reg(3'd4, 16'h0001);
    bus_read(3'd4, d);
    checkOutput("match_set_wins", {15'd0, d[0]}, 16'h0001);
    write_reg(3'd0, 16'h0000);
    write_reg(3'd4, 16'h0007);

    // Input capture.
    write_reg(3'd1, 16'h0010);
    cap_level = 1'b1;
    idle(1);
    cap_level = 1'b0;
    idle(1);
    bus_read(3'd5, d);
    checkOutput("cap_value", d, CAP_ON ? 16'h0010 : 16'h0000);
    bus_read(3'd4, d);
    checkOutput("capf_flag", {15'd0, d[2]}, {15'd0, CAP_ON});

    // Reset during RD_DATA drops the read.
    write_reg(3'd2, 16'h0005);
    write_reg(3'd3, 16'h0002);
    write_reg(3'd1, 16'h0003);
    write_reg(3'd0, 16'h0007);
    applyStimulus(1'b0, 1'b1, reg_addr(3'd2), 1'b0, 1'b1, 16'h0, dummy);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, dummy);
    checkOutput("rst_rd_rdy", {15'd0, o_rdy}, 16'h0001);
    checkOutput("rst_rd_data", o_rdata, 16'h0000);
    for (int r = 0; r < 8; r++) begin
      bus_read(3'(r), d);
      checkOutput("rst_rd_reg", d, (r == 2) ? 16'hFFFF : 16'h0000);
    end

    // Random bus traffic checked cycle by cycle against the model.
    for (int it = 0; it < 600; it++) begin
      op = int'($urandom_range(0, 19));
      cap_level = ($urandom_range(0, 3) == 0);
      if (op < 6) begin
        a = reg_addr(3'($urandom_range(0, 7)));
        case (a[3:1])
          3'd1:    d = ($urandom_range(0, 1) == 1) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom_range(0, 20));
          3'd2:    d = 16'($urandom_range(0, 24));
          3'd3:    d = 16'($urandom_range(0, 3));
          default: d = 16'($urandom);
        endcase
        applyStimulus(1'b0, 1'b1, a, 1'b1, 1'b0, d, dummy);
      end else if (op < 12) begin
        applyStimulus(1'b0, 1'b1, reg_addr(3'($urandom_range(0, 7))), 1'b0, 1'b1, 16'h0, dummy);
      end else if (op < 16) begin
        idle(1);
      end else if (op < 19) begin
        a = 16'($urandom);
        if (a[15:8] == 8'h81) a[8] = 1'b0;
        applyStimulus(1'b0, ($urandom_range(0, 1) == 1), a, ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 1) == 1), 16'($urandom), dummy);
      end else begin
        applyStimulus(($urandom_range(0, 4) == 0), 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, dummy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
